uart_rx: RTL

UART receiver that pairs with the transmitter stage. It deserializes the line driven by `DATA_OUT_Tx`, or by an external pin, into parallel bytes. It supports 7- or 8-bit frames and optional odd parity, with the same `UART_BITS`/`UART_PARITY` encoding as the transmitter. Received data is held until the CPU side acknowledges it, and error flags and an interrupt pulse are reported per frame.

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 7/8 data bits, optional odd parity, held byte with per-frame flags and IRQ pulse.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit (adds one cycle of latency).
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       DATA_IN_Rx,
  input  logic       UART_BITS,
  input  logic       UART_PARITY,
  input  logic       UART_READ,
  output logic [7:0] DATA_OUT_Rx,
  output logic       DATA_READY,
  output logic       IRQ_Rx,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  // One extra cycle so the decision lands at mid+1 with mid-1 and mid in history.
  localparam logic [CW-1:0] START_LOAD = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          sync0;
  logic          rx_s;
  logic          rx_d1;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bits8;
  logic          par_en;
  logic          par_acc;
  logic          par_bad;
  logic          tick;
  logic          sample;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;

  always_ff @(posedge clk) begin
    if (RST) rx_d2 <= 1'b1;
    else     rx_d2 <= rx_d1;
  end

  always_comb begin
    sample = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
  end
`else
  always_comb begin
    sample = rx_s;
  end
`endif

  always_comb begin
    tick = (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync0 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d1 <= 1'b1;
    end else begin
      sync0 <= DATA_IN_Rx;
      rx_s  <= sync0;
      rx_d1 <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      bits8       <= 1'b0;
      par_en      <= 1'b0;
      par_acc     <= 1'b0;
      par_bad     <= 1'b0;
      DATA_OUT_Rx <= '0;
      DATA_READY  <= 1'b0;
      IRQ_Rx      <= 1'b0;
      PARITY_ERR  <= 1'b0;
      FRAME_ERR   <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      IRQ_Rx <= 1'b0;
      if (UART_READ && DATA_READY) begin
        DATA_READY <= 1'b0;
        PARITY_ERR <= 1'b0;
        FRAME_ERR  <= 1'b0;
        OVERRUN    <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Edge-triggered start, so a line stuck low never retriggers.
          if (rx_d1 && !rx_s) begin
            cnt   <= START_LOAD;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (sample) begin
              state <= IDLE;
            end else begin
              bits8   <= UART_BITS;
              par_en  <= UART_PARITY;
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
              shreg   <= '0;
              par_acc <= 1'b0;
              par_bad <= 1'b0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg[bit_idx] <= sample;
            par_acc        <= par_acc ^ sample;
            cnt            <= BIT_LOAD;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == {2'b11, bits8}) state <= par_en ? PARITY : STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PARITY: begin
          if (tick) begin
            par_bad <= ~(par_acc ^ sample);
            cnt     <= BIT_LOAD;
            state   <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            if (!DATA_READY || UART_READ) begin
              DATA_OUT_Rx <= bits8 ? shreg : {1'b0, shreg[6:0]};
              DATA_READY  <= 1'b1;
              PARITY_ERR  <= par_bad;
              FRAME_ERR   <= ~sample;
              OVERRUN     <= 1'b0;
              IRQ_Rx      <= 1'b1;
            end else begin
              OVERRUN <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
